// File: rtl/rv32_pkg.sv
// Shared RV32I encodings: opcodes, control FSM states and datapath mux encodings.
// Used by the multi-cycle controller, the immediate generator and the datapath.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Bit positions of the one-hot instruction class vector.
    localparam int CLS_LUI    = 0;
    localparam int CLS_AUIPC  = 1;
    localparam int CLS_JAL    = 2;
    localparam int CLS_JALR   = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_LOAD   = 5;
    localparam int CLS_STORE  = 6;
    localparam int CLS_OP_IMM = 7;
    localparam int CLS_OP     = 8;
    localparam int CLS_N      = 9;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_t;

    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;

    localparam logic ALU_B_RS2 = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4     = 2'd0;
    localparam logic [1:0] PC_ALU       = 2'd1;
    localparam logic [1:0] PC_ALU_ALIGN = 2'd2;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

endpackage

// File: rtl/rv32_opcode_decode.sv
// Combinational opcode classifier: one-hot instruction class plus an illegal flag
// for any opcode outside the supported RV32I base set.
module rv32_opcode_decode
    import rv32_pkg::*;
(
    input  logic [6:0]       opcode,
    output logic [CLS_N-1:0] cls,
    output logic             illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_LUI:    cls[CLS_LUI]    = 1'b1;
            OPC_AUIPC:  cls[CLS_AUIPC]  = 1'b1;
            OPC_JAL:    cls[CLS_JAL]    = 1'b1;
            OPC_JALR:   cls[CLS_JALR]   = 1'b1;
            OPC_BRANCH: cls[CLS_BRANCH] = 1'b1;
            OPC_LOAD:   cls[CLS_LOAD]   = 1'b1;
            OPC_STORE:  cls[CLS_STORE]  = 1'b1;
            OPC_OP_IMM: cls[CLS_OP_IMM] = 1'b1;
            OPC_OP:     cls[CLS_OP]     = 1'b1;
            default:    cls = '0;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// request handshake with a wait-cycle timeout, and a sticky trap state.
module rv32_multicycle_ctrl
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        alu_funct_en,
    output logic [1:0]  wb_sel,
    output logic [1:0]  pc_src,
    output logic        retire,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    // A zero limit disables the timeout but still needs a legal 1-bit counter.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    ctrl_state_t      state_q, state_d;
    logic [1:0]       trap_cause_q, trap_cause_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;
    logic             tmo_hit;

    logic [CLS_N-1:0] cls;
    logic             illegal;
    logic             is_load, is_store, is_branch;
    logic [1:0]       ex_alu_a;
    logic             ex_alu_b, ex_funct_en;
    logic             unused_instr_bits;

    rv32_opcode_decode u_decode (
        .opcode  (instr[6:0]),
        .cls     (cls),
        .illegal (illegal)
    );

    assign is_load   = cls[CLS_LOAD];
    assign is_store  = cls[CLS_STORE];
    assign is_branch = cls[CLS_BRANCH];
    assign unused_instr_bits = ^instr[31:12];

    // Limit is reached on the wait cycle that would bring the count to TIMEOUT_CYCLES.
    assign tmo_cnt_inc = tmo_cnt_q + CNT_W'(1);
    assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // ALU operand selection depends only on the class, so it holds from EXEC onward.
    always_comb begin
        ex_alu_a    = ALU_A_RS1;
        ex_alu_b    = ALU_B_IMM;
        ex_funct_en = 1'b0;
        if (cls[CLS_OP]) begin
            ex_alu_b    = ALU_B_RS2;
            ex_funct_en = 1'b1;
        end
        if (cls[CLS_OP_IMM]) begin
            ex_funct_en = 1'b1;
        end
        if (cls[CLS_BRANCH] || cls[CLS_JAL] || cls[CLS_AUIPC]) begin
            ex_alu_a = ALU_A_PC;
        end
        if (cls[CLS_LUI]) begin
            ex_alu_a = ALU_A_ZERO;
        end
    end

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        tmo_cnt_d    = '0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (tmo_hit) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_TIMEOUT;
                end else begin
                    tmo_cnt_d = tmo_cnt_inc;
                end
            end
            ST_DECODE: begin
                if (illegal) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else if (is_branch) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = is_store ? ST_FETCH : ST_WB;
                end else if (tmo_hit) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_TIMEOUT;
                end else begin
                    tmo_cnt_d = tmo_cnt_inc;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            trap_cause_q <= TRAP_NONE;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // All defaults are the zero encodings, so gating on rst_n silences every output.
    always_comb begin
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        rf_we        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_a_sel    = ALU_A_RS1;
        alu_b_sel    = ALU_B_RS2;
        alu_funct_en = 1'b0;
        wb_sel       = WB_ALU;
        pc_src       = PC_PLUS4;
        retire       = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                ST_EXEC: begin
                    alu_a_sel    = ex_alu_a;
                    alu_b_sel    = ex_alu_b;
                    alu_funct_en = ex_funct_en;
                    if (is_branch) begin
                        pc_we  = 1'b1;
                        pc_src = br_taken ? PC_ALU : PC_PLUS4;
                        retire = 1'b1;
                    end
                end
                ST_MEM: begin
                    alu_a_sel    = ex_alu_a;
                    alu_b_sel    = ex_alu_b;
                    alu_funct_en = ex_funct_en;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_store;
                    if (mem_ready && is_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                ST_WB: begin
                    alu_a_sel    = ex_alu_a;
                    alu_b_sel    = ex_alu_b;
                    alu_funct_en = ex_funct_en;
                    rf_we        = (instr[11:7] != 5'd0);
                    pc_we        = 1'b1;
                    retire       = 1'b1;
                    if (is_load) begin
                        wb_sel = WB_MEM;
                    end else if (cls[CLS_JAL] || cls[CLS_JALR]) begin
                        wb_sel = WB_PC4;
                    end
                    if (cls[CLS_JAL]) begin
                        pc_src = PC_ALU;
                    end else if (cls[CLS_JALR]) begin
                        pc_src = PC_ALU_ALIGN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign trap_cause = trap_cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Bench for rv32_multicycle_ctrl: directed and random instruction streams with
// randomized memory waits, checked by a scoreboard fed from a per-instruction model.
module tb_rv32_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic        pc_we, ir_we, rf_we, mem_req, mem_we, mem_addr_sel;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel, alu_funct_en;
    logic [1:0]  wb_sel, pc_src;
    logic        retire;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    rv32_multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .br_taken     (br_taken),
        .pc_we        (pc_we),
        .ir_we        (ir_we),
        .rf_we        (rf_we),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_funct_en (alu_funct_en),
        .wb_sel       (wb_sel),
        .pc_src       (pc_src),
        .retire       (retire),
        .trap_cause   (trap_cause),
        .state        (state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference tables ----------------
    localparam int C_LUI = 0, C_AUIPC = 1, C_JAL = 2, C_JALR = 3, C_BR = 4;
    localparam int C_LD = 5, C_ST = 6, C_OPI = 7, C_OP = 8;
    logic [6:0] opc_tab [0:8] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                  7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                  7'b0110011};

    typedef struct packed {
        logic [1:0] kind;      // 0 retire, 1 illegal trap, 2 timeout trap
        logic [7:0] cycles;
        logic [7:0] exec_cyc;
        logic [1:0] alu_a;
        logic       alu_b;
        logic       fen;
        logic [1:0] pc_src;
        logic [1:0] wb_sel;
        logic       chk_wb;
        logic       n_rf;
        logic [7:0] n_freq;
        logic [7:0] n_mreq;
        logic [7:0] n_mwe;
    } exp_t;
    localparam int W = $bits(exp_t);
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected per-instruction outcome computed from the instruction-level rules.
    function automatic exp_t model(input int cls, input logic [4:0] rd, input int fw,
                                   input int mw, input logic br);
        exp_t e;
        logic is_mem;
        int   base;
        e = '0;
        is_mem = (cls == C_LD) || (cls == C_ST);
        base = (cls == C_BR) ? 3 : (cls == C_LD) ? 5 : 4;
        e.kind     = 2'd0;
        e.cycles   = 8'(base + fw + (is_mem ? mw : 0));
        e.exec_cyc = 8'(fw + 3);
        case (cls)
            C_OP:                  begin e.alu_a = 2'd0; e.alu_b = 1'b0; e.fen = 1'b1; end
            C_OPI:                 begin e.alu_a = 2'd0; e.alu_b = 1'b1; e.fen = 1'b1; end
            C_LD, C_ST, C_JALR:    begin e.alu_a = 2'd0; e.alu_b = 1'b1; e.fen = 1'b0; end
            C_BR, C_JAL, C_AUIPC:  begin e.alu_a = 2'd1; e.alu_b = 1'b1; e.fen = 1'b0; end
            default:               begin e.alu_a = 2'd2; e.alu_b = 1'b1; e.fen = 1'b0; end
        endcase
        e.pc_src = (cls == C_BR) ? (br ? 2'd1 : 2'd0) :
                   (cls == C_JAL) ? 2'd1 : (cls == C_JALR) ? 2'd2 : 2'd0;
        e.wb_sel = (cls == C_LD) ? 2'd1 : (cls == C_JAL || cls == C_JALR) ? 2'd2 : 2'd0;
        e.chk_wb = !(cls == C_BR || cls == C_ST);
        e.n_rf   = e.chk_wb && (rd != 5'd0);
        e.n_freq = 8'(fw + 1);
        e.n_mreq = is_mem ? 8'(mw + 1) : 8'd0;
        e.n_mwe  = (cls == C_ST) ? 8'(mw + 1) : 8'd0;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] iw, input int cls, input int fw,
                             input int mw, input logic br);
        exp_t e;
        logic mem_op;
        int   len;
        mem_op = (cls == C_LD) || (cls == C_ST);
        e = model(cls, iw[11:7], fw, mw, br);
        exp_q.push_back(e);
        instr    = iw;
        br_taken = br;
        len = 3 + fw + ((cls == C_BR) ? 0 : 1) + (mem_op ? mw + (cls == C_LD ? 1 : 0) : 0);
        for (int c = 1; c <= len; c++) begin
            if (c <= fw) mem_ready = 1'b0;
            else if (c == fw + 1) mem_ready = 1'b1;
            else if (mem_op && c >= fw + 4 && c < fw + 4 + mw) mem_ready = 1'b0;
            else if (mem_op && c == fw + 4 + mw) mem_ready = 1'b1;
            else mem_ready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic hold_trap(input logic [1:0] cause, input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("trap_enables", {pc_we, ir_we, rf_we, mem_req, mem_we, retire}, 6'd0);
            check("trap_cause_hold", trap_cause, cause);
            tick();
        end
    endtask

    task automatic run_illegal(input logic [31:0] iw, input int fw);
        exp_t e;
        e = '0;
        e.kind   = 2'd1;
        e.cycles = 8'(fw + 3);
        exp_q.push_back(e);
        instr = iw;
        for (int c = 1; c <= fw + 2; c++) begin
            if (c <= fw) mem_ready = 1'b0;
            else if (c == fw + 1) mem_ready = 1'b1;
            else mem_ready = 1'($urandom_range(0, 1));
            tick();
        end
        hold_trap(2'd1, 20);
    endtask

    task automatic run_timeout(input logic in_mem);
        exp_t e;
        e = '0;
        e.kind   = 2'd2;
        e.cycles = in_mem ? 8'd20 : 8'd17;
        exp_q.push_back(e);
        instr = in_mem ? 32'h00402083 : 32'h00C00093;
        for (int c = 1; c <= (in_mem ? 19 : 16); c++) begin
            if (!in_mem) mem_ready = 1'b0;
            else if (c == 1) mem_ready = 1'b1;
            else if (c <= 3) mem_ready = 1'($urandom_range(0, 1));
            else mem_ready = 1'b0;
            tick();
        end
        hold_trap(2'd2, 20);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check("reset_outputs", {pc_we, ir_we, rf_we, mem_req, mem_we, retire, mem_addr_sel,
                                alu_a_sel, alu_b_sel, alu_funct_en, wb_sel, pc_src}, 0);
        @(negedge clk);
        check("reset_state", state, 3'd0);
        check("reset_trap_cause", trap_cause, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("release_mem_req", {mem_req, mem_addr_sel}, 2'b10);
    endtask

    task automatic run_sw_reset();
        instr = 32'h00102223;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'($urandom_range(0, 1));
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        check("sw_mem_phase", {mem_req, mem_we, mem_addr_sel}, 3'b111);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {mem_req, mem_we, pc_we, rf_we, ir_we, retire}, 6'd0);
        check("abort_state", state, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("restart_fetch", {state, mem_req}, {3'd0, 1'b1});
    endtask

    // ---------------- monitor / scoreboard ----------------
    int         m_cyc, n_freq, n_mreq, n_mwe, n_rf, n_pc, n_ir;
    logic [1:0] m_a, prev_tc;
    logic       m_b, m_f;
    exp_t       h;

    task automatic clear_counts();
        m_cyc = 0; n_freq = 0; n_mreq = 0; n_mwe = 0; n_rf = 0; n_pc = 0; n_ir = 0;
        m_a = 2'd3; m_b = 1'b0; m_f = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            clear_counts();
            prev_tc = 2'd0;
        end else begin
            m_cyc++;
            if (mem_req && !mem_addr_sel) n_freq++;
            if (mem_req && mem_addr_sel) n_mreq++;
            if (mem_we) n_mwe++;
            if (rf_we) n_rf++;
            if (pc_we) n_pc++;
            if (ir_we) n_ir++;
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                if (m_cyc == int'(h.exec_cyc)) begin
                    m_a = alu_a_sel; m_b = alu_b_sel; m_f = alu_funct_en;
                end
            end
            if (retire) begin
                check("retire_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    h = exp_q.pop_front();
                    check("retire_kind", 2'd0, h.kind);
                    check("latency", m_cyc, h.cycles);
                    check("exec_alu_sel", {m_a, m_b, m_f}, {h.alu_a, h.alu_b, h.fen});
                    check("retire_pc", {pc_we, pc_src}, {1'b1, h.pc_src});
                    if (h.chk_wb) check("retire_wb_sel", wb_sel, h.wb_sel);
                    check("we_counts", {8'(n_ir), 8'(n_pc), 8'(n_rf)}, {8'd1, 8'd1, 7'd0, h.n_rf});
                    check("mem_req_counts", {8'(n_freq), 8'(n_mreq), 8'(n_mwe)},
                          {h.n_freq, h.n_mreq, h.n_mwe});
                end
                clear_counts();
            end else if (trap_cause != 2'd0 && prev_tc == 2'd0) begin
                check("trap_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    h = exp_q.pop_front();
                    check("trap_kind", trap_cause, h.kind);
                    check("trap_latency", m_cyc, h.cycles);
                end
                clear_counts();
            end
            prev_tc = trap_cause;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r, iw;
        logic [4:0]  rd;
        int          cls;
        rst_n = 1'b1;
        instr = 32'h0;
        mem_ready = 1'b0;
        br_taken = 1'b0;
        tick();
        do_reset();

        run_instr(32'h00C00093, C_OPI, 0, 0, 1'b0);
        run_instr(32'h00402083, C_LD, 0, 3, 1'b0);
        run_instr(32'hFE100EE3, C_BR, 0, 0, 1'b1);
        run_instr(32'hFE100EE3, C_BR, 0, 0, 1'b0);
        run_instr(32'h008000EF, C_JAL, 0, 0, 1'b0);
        run_instr(32'h008000E7, C_JALR, 0, 0, 1'b0);
        run_instr(32'h00102223, C_ST, 1, 2, 1'b0);
        run_instr(32'h123450B7, C_LUI, 0, 0, 1'b0);
        run_instr(32'h00001117, C_AUIPC, 2, 0, 1'b0);
        run_instr(32'h002081B3, C_OP, 0, 0, 1'b0);
        run_instr(32'h00100013, C_OPI, 0, 0, 1'b0);
        // Ready arriving on the 16th wait cycle must complete, not trap.
        run_instr(32'h00C00093, C_OPI, 15, 0, 1'b0);
        run_instr(32'h00402083, C_LD, 0, 15, 1'b0);

        for (int i = 0; i < 40; i++) begin
            cls = $urandom_range(0, 8);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r   = $urandom();
            iw  = {r[31:12], rd, opc_tab[cls]};
            run_instr(iw, cls, $urandom_range(0, 4), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)));
        end

        run_illegal(32'h00000000, 0);
        do_reset();
        run_illegal(32'h12345678, 2);
        do_reset();
        run_timeout(1'b0);
        do_reset();
        run_timeout(1'b1);
        do_reset();
        run_sw_reset();
        run_instr(32'h00C00093, C_OPI, 0, 0, 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32_multicycle_ctrl.md
# rv32_multicycle_ctrl

Multi-cycle control FSM for the RV32I datapath. It sequences instruction fetch, decode, execute, memory access and writeback around the shared ALU, register file, instruction register, PC and the existing immediate generator. Each cycle it drives the datapath write-enables, mux selects and the memory request handshake. Illegal opcodes and memory timeouts park it in a sticky trap state.

## Interface
- TIMEOUT_CYCLES, 16: number of consecutive `mem_req && !mem_ready` cycles that causes a trap; 0 disables the timeout.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- instr  in  32  instruction register contents; valid from DECODE onward
- mem_ready  in  1  memory completes the access in the current cycle
- br_taken  in  1  branch comparator result; valid in EXEC
- pc_we, ir_we, rf_we  out  1 each  PC, IR and register-file write enables
- mem_req, mem_we  out  1 each  memory request; store when mem_we=1
- mem_addr_sel  out  1  0=PC, 1=ALU result
- alu_a_sel  out  2  0=rs1, 1=PC, 2=zero
- alu_b_sel  out  1  0=rs2, 1=imm
- alu_funct_en  out  1  0=force ADD, 1=ALU decodes funct3/funct7
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4
- pc_src  out  2  0=PC+4, 1=ALU result, 2=ALU result & ~1
- retire  out  1  one-cycle pulse when an instruction completes
- trap_cause  out  2  0=none, 1=illegal opcode, 2=memory timeout
- state  out  3  current FSM state (debug)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **FETCH:** mem_req=1, mem_addr_sel=0. When mem_ready is high, ir_we=1 and the FSM goes to DECODE; otherwise it stays in FETCH.
- **DECODE:** classifies instr[6:0]:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Any other opcode, including all-zero, goes to TRAP with trap_cause=1.
  - Any legal opcode goes to EXEC.
- **EXEC ALU selects:**
  - OP: a=rs1, b=rs2, funct_en=1.
  - OP-IMM: a=rs1, b=imm, funct_en=1.
  - LOAD, STORE, JALR: a=rs1, b=imm, ADD.
  - BRANCH, JAL, AUIPC: a=PC, b=imm, ADD.
  - LUI: a=zero, b=imm, ADD.
- **EXEC next state:**
  - LOAD and STORE go to MEM.
  - BRANCH completes here: pc_we=1, pc_src = br_taken ? 1 : 0, retire=1, next state FETCH.
  - All other legal opcodes go to WB.
- **MEM:** mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. ALU selects are held from EXEC.
  - On mem_ready, STORE asserts pc_we=1, pc_src=0, retire=1 and goes to FETCH.
  - On mem_ready, LOAD goes to WB.
- **WB:** rf_we = (instr[11:7] != 0). pc_we=1 and retire=1, then FETCH.
  - wb_sel=1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_src=1 for JAL, 2 for JALR, 0 otherwise.
- **TRAP:** all enables and mem_req are 0. trap_cause holds its value. The only exit is reset.
- **Timeout counter:**
  - Counts cycles in FETCH/MEM with mem_ready=0.
  - Clears on mem_ready or on a state change.
  - Reaching TIMEOUT_CYCLES goes to TRAP with trap_cause=2; mem_req is 0 from the next cycle.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Outputs other than state and trap_cause are combinational from the state, the decoded opcode and mem_ready. Registered: state, trap_cause, timeout counter.

## Timing
- **Reset:** while rst_n=0, state=FETCH, trap_cause=0, counter=0, and every output is 0, including mem_req (gated by rst_n).
- **After reset:** the first cycle after rst_n rises drives mem_req=1.
- **Reset mid-operation:** reset asserted in any state, including mid-MEM or TRAP, aborts immediately. No partial pc_we, rf_we or mem_we may be issued after rst_n falls.
- **Latency with mem_ready always high:**
  - BRANCH: 3 cycles.
  - STORE, OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- **Handshake:** mem_req stays asserted, with stable mem_we and mem_addr_sel, until the cycle mem_ready=1. mem_ready outside FETCH/MEM is ignored.
- **Retire pulses:** retire is high exactly one cycle per instruction, in the same cycle as the final pc_we.
- **Simultaneous events:** mem_ready=1 in the same cycle the timeout limit is reached means the access completes and there is no trap.

## Structure
- **Package rv32_pkg** holds:
  - opcode localparams;
  - the state enum `ctrl_state_t`;
  - encodings for alu_a_sel, wb_sel, pc_src and trap_cause;
  - shared with imm_gen and the datapath.
- **Sub-module rv32_opcode_decode:** combinational. Maps instr[6:0] to a one-hot instruction class plus an illegal flag.

## Test plan
- Reset, then release with mem_ready=1 and instr=0x00C00093 (ADDI) → FETCH, DECODE, EXEC, WB. In WB: rf_we=1, wb_sel=0, pc_we=1, pc_src=0, retire pulse on cycle 4.
- instr=0x00402083 (LW) with mem_ready low for 3 MEM cycles → mem_req, mem_addr_sel=1 held for 4 cycles; then WB with wb_sel=1; 8 cycles total.
- instr=0xFE100EE3 (BEQ): br_taken=1 → pc_src=1 in EXEC; br_taken=0 → pc_src=0; 3 cycles each. JAL 0x008000EF → wb_sel=2, pc_src=1. JALR 0x008000E7 → pc_src=2.
- instr=0x00000000 and 0x12345678 → TRAP, trap_cause=1, all enables 0 for 20 cycles; rst_n low recovers to FETCH.
- mem_ready held 0 in FETCH with TIMEOUT_CYCLES=16 → trap_cause=2 after 16 cycles. A run where mem_ready rises on cycle 16 → no trap.
- rst_n pulsed low mid-MEM of SW 0x00102223 → mem_req and mem_we drop immediately, no retire; restart in FETCH.
